// File: rtl/nexys_starship_lanes.sv
`default_nettype none
// ============================================================================
// Module      : nexys_starship_lanes
// Description : Multi-lane monster game controller. One INIT/PLAY/OVER game
//               FSM drives NUM_LANES monster lanes. Monsters spawn at
//               pseudo-random lanes and each has an attack timer. Kills from
//               the shooter logic clear lanes and add to a saturating score.
// Ports       : Clk        - system clock
//               Reset      - asynchronous, active-high reset
//               play_flag  - level, start / continue game
//               kill       - per-lane shot pulse
//               q_Init/q_Play/q_Over - one-hot state bits
//               lane_full  - monster present per lane
//               game_over  - registered, high throughout OVER
//               score      - kills this game, saturates at 16'hFFFF
// Revision    : 1.0 - initial release
// ============================================================================
module nexys_starship_lanes #(
    parameter int          NUM_LANES    = 4,
    parameter int          TIMER_W      = 28,
    parameter int          ATTACK_TICKS = 150_000_000,
    parameter int          SPAWN_GAP    = 50_000_000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 play_flag,
    input  logic [NUM_LANES-1:0] kill,
    output logic                 q_Init,
    output logic                 q_Play,
    output logic                 q_Over,
    output logic [NUM_LANES-1:0] lane_full,
    output logic                 game_over,
    output logic [15:0]          score
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    localparam logic [2:0] ST_INIT = 3'b001;
    localparam logic [2:0] ST_PLAY = 3'b010;
    localparam logic [2:0] ST_OVER = 3'b100;

    localparam logic [TIMER_W-1:0] SPAWN_LAST  = TIMER_W'(SPAWN_GAP - 1);
    localparam logic [TIMER_W-1:0] ATTACK_LAST = TIMER_W'(ATTACK_TICKS - 1);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [15:0]          lfsr;
    logic [TIMER_W-1:0]   spawn_cnt;
    logic [TIMER_W-1:0]   lane_timer [NUM_LANES];
    logic                 in_play;
    logic                 spawn_tick;
    logic [LANE_W-1:0]    spawn_lane;
    logic [NUM_LANES-1:0] kill_ok;
    logic [NUM_LANES-1:0] expire;
    logic [NUM_LANES-1:0] spawn_hit;
    logic [NUM_LANES-1:0] lane_nxt;
    logic [3:0]           kill_cnt;
    logic [16:0]          score_sum;

    assign q_Init = state[0];
    assign q_Play = state[1];
    assign q_Over = state[2];

    assign in_play    = (state == ST_PLAY);
    assign spawn_tick = in_play && (spawn_cnt == SPAWN_LAST);

    generate
        if (NUM_LANES > 1) begin : g_lane_multi
            assign spawn_lane = lfsr[LANE_W-1:0];
        end else begin : g_lane_single
            assign spawn_lane = '0;
        end
    endgenerate

    // Per-lane resolution: a valid kill beats both expiry and a spawn on the
    // same lane; a spawn onto an already full lane simply leaves it full.
    always_comb begin
        kill_ok   = '0;
        expire    = '0;
        spawn_hit = '0;
        kill_cnt  = '0;
        lane_nxt  = lane_full;
        for (int i = 0; i < NUM_LANES; i++) begin
            kill_ok[i]   = in_play & kill[i] & lane_full[i];
            expire[i]    = in_play & lane_full[i] & ~kill[i] &
                           (lane_timer[i] == ATTACK_LAST);
            spawn_hit[i] = spawn_tick & (spawn_lane == LANE_W'(i));
            kill_cnt     = kill_cnt + {3'b000, kill_ok[i]};
            if (kill_ok[i]) begin
                lane_nxt[i] = 1'b0;
            end else if (spawn_hit[i]) begin
                lane_nxt[i] = 1'b1;
            end
        end
    end

    assign score_sum = {1'b0, score} + {13'b0, kill_cnt};

    always_comb begin
        state_nxt = ST_INIT;
        case (state)
            ST_INIT: state_nxt = play_flag ? ST_PLAY : ST_INIT;
            ST_PLAY: state_nxt = (|expire) ? ST_OVER : ST_PLAY;
            ST_OVER: state_nxt = play_flag ? ST_OVER : ST_INIT;
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_INIT;
            lfsr      <= LFSR_SEED;
            spawn_cnt <= '0;
            lane_full <= '0;
            game_over <= 1'b0;
            score     <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_timer[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            game_over <= (state_nxt == ST_OVER);

            if (state == ST_INIT && state_nxt == ST_PLAY) begin
                score     <= '0;
                spawn_cnt <= '0;
            end else if (in_play) begin
                spawn_cnt <= spawn_tick ? '0 : spawn_cnt + TIMER_W'(1);
                score     <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            end

            if (state_nxt == ST_INIT) begin
                lane_full <= '0;
            end else if (in_play) begin
                lane_full <= lane_nxt;
            end

            // Timers run only for lanes that stay occupied; a freshly spawned
            // monster starts from zero. Outside PLAY they hold only while OVER.
            for (int i = 0; i < NUM_LANES; i++) begin
                if (in_play) begin
                    lane_timer[i] <= (lane_full[i] && lane_nxt[i]) ?
                                     lane_timer[i] + TIMER_W'(1) : '0;
                end else if (state_nxt != ST_OVER) begin
                    lane_timer[i] <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nexys_starship_lanes.sv
`default_nettype none
// ============================================================================
// Module      : tb_nexys_starship_lanes
// Description : Self-checking bench for nexys_starship_lanes. A short-timer
//               instance covers spawn timing, expiry, kill priority and reset;
//               a long-timer instance covers multi-kill scoring and full lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nexys_starship_lanes;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        play_flag = 1'b0;
    logic [3:0]  kill = 4'h0;
    logic        q_Init, q_Play, q_Over, game_over;
    logic [3:0]  lane_full;
    logic [15:0] score;

    logic        play_flag_b = 1'b0;
    logic [3:0]  kill_b = 4'h0;
    logic        q_Init_b, q_Play_b, q_Over_b, game_over_b;
    logic [3:0]  lane_full_b;
    logic [15:0] score_b;

    int checks = 0;
    int passed = 0;

    logic [15:0] m_lfsr;

    typedef struct {
        logic        play;
        logic [3:0]  kill;
        logic [2:0]  exp_q;      // {Over, Play, Init}
        logic [3:0]  exp_lane;
        logic        exp_go;
        logic [15:0] exp_score;
    } vec_t;

    vec_t vecs [7];

    nexys_starship_lanes #(
        .NUM_LANES(4), .TIMER_W(28), .ATTACK_TICKS(10), .SPAWN_GAP(5),
        .LFSR_SEED(16'hACE1)
    ) u_dut (
        .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .kill(kill),
        .q_Init(q_Init), .q_Play(q_Play), .q_Over(q_Over),
        .lane_full(lane_full), .game_over(game_over), .score(score)
    );

    nexys_starship_lanes #(
        .NUM_LANES(4), .TIMER_W(28), .ATTACK_TICKS(400), .SPAWN_GAP(5),
        .LFSR_SEED(16'hACE1)
    ) u_dut_long (
        .Clk(Clk), .Reset(Reset), .play_flag(play_flag_b), .kill(kill_b),
        .q_Init(q_Init_b), .q_Play(q_Play_b), .q_Over(q_Over_b),
        .lane_full(lane_full_b), .game_over(game_over_b), .score(score_b)
    );

    always #5 Clk = ~Clk;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting left.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0] l1, l2, l3;
        logic [3:0] exp3, kmask, emask;
        logic       early;
        int         n, cnt;

        vecs[0] = '{1'b0, 4'h0, 3'b001, 4'h0, 1'b0, 16'h0};
        vecs[1] = '{1'b0, 4'hF, 3'b001, 4'h0, 1'b0, 16'h0};  // kill ignored in INIT
        vecs[2] = '{1'b1, 4'h0, 3'b010, 4'h0, 1'b0, 16'h0};  // PLAY entry
        vecs[3] = '{1'b0, 4'h1, 3'b010, 4'h0, 1'b0, 16'h0};  // kill on empty lane
        vecs[4] = '{1'b0, 4'h0, 3'b010, 4'h0, 1'b0, 16'h0};
        vecs[5] = '{1'b0, 4'hA, 3'b010, 4'h0, 1'b0, 16'h0};
        vecs[6] = '{1'b0, 4'h0, 3'b010, 4'h0, 1'b0, 16'h0};  // 4th PLAY edge, no spawn yet

        // Reset state
        repeat (2) tick();
        check("reset_state", {q_Over, q_Play, q_Init, lane_full, game_over, score},
              {3'b001, 4'h0, 1'b0, 16'h0});
        check("reset_state_b", {q_Over_b, q_Play_b, q_Init_b, lane_full_b, game_over_b, score_b},
              {3'b001, 4'h0, 1'b0, 16'h0});
        Reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            play_flag = vecs[i].play;
            kill      = vecs[i].kill;
            tick();
            check($sformatf("vec%0d", i), {q_Over, q_Play, q_Init, lane_full, game_over, score},
                  {vecs[i].exp_q, vecs[i].exp_lane, vecs[i].exp_go, vecs[i].exp_score});
        end
        play_flag = 1'b0;
        kill      = 4'h0;

        // First spawn on the 5th PLAY edge at lane lfsr[1:0]
        l1 = m_lfsr[1:0];
        tick();
        check("first_spawn", {q_Over, q_Play, q_Init, lane_full}, {3'b010, 4'b0001 << l1});

        // Unkilled monster expires exactly 10 cycles later
        early = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (game_over) early = 1'b1;
        end
        check("no_early_over", early, 1'b0);
        tick();
        check("expire_at_10", {q_Over, q_Play, q_Init, game_over, score}, {3'b100, 1'b1, 16'h0});
        tick();
        check("over_to_init", {q_Over, q_Play, q_Init, lane_full, game_over, score},
              {3'b001, 4'h0, 1'b0, 16'h0});

        // Kill on the expiry cycle wins
        play_flag = 1'b1;
        tick();
        check("replay", {q_Over, q_Play, q_Init, score}, {3'b010, 16'h0});
        play_flag = 1'b0;
        repeat (4) tick();
        l1 = m_lfsr[1:0];
        tick();
        check("spawn_game2", lane_full, 4'b0001 << l1);
        repeat (4) tick();
        l2 = m_lfsr[1:0];
        tick();
        repeat (4) tick();
        l3 = m_lfsr[1:0];
        kill = 4'b0001 << l1;
        tick();
        kill = 4'h0;
        exp3 = ((4'b0001 << l1) | (4'b0001 << l2) | (4'b0001 << l3)) & ~(4'b0001 << l1);
        check("kill_beats_expiry", {q_Over, q_Play, game_over, score}, {2'b01, 1'b0, 16'd1});
        check("kill_lane_after", lane_full, exp3);

        // Kill on an empty lane: no score, lanes unchanged
        emask = 4'h0;
        for (int i = 3; i >= 0; i--) if (!exp3[i]) emask = 4'b0001 << i;
        kill = emask;
        tick();
        kill = 4'h0;
        check("empty_kill", {lane_full, score}, {exp3, 16'd1});

        n = 0;
        while (!game_over && n < 200) begin tick(); n++; end
        check("eventual_over", {q_Over, game_over, score}, {1'b1, 1'b1, 16'd1});
        tick();
        check("init_score_held", {q_Over, q_Play, q_Init, lane_full, game_over, score},
              {3'b001, 4'h0, 1'b0, 16'd1});

        // Long-timer instance: double kill, then all lanes full
        play_flag_b = 1'b1;
        tick();
        play_flag_b = 1'b0;
        check("b_play", q_Play_b, 1'b1);
        n = 0;
        while ($countones(lane_full_b) < 2 && !game_over_b && n < 400) begin tick(); n++; end
        check("b_two_full", $countones(lane_full_b), 32'd2);
        kmask = 4'h0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (lane_full_b[i] && cnt < 2) begin kmask[i] = 1'b1; cnt++; end
        end
        kill_b = kmask;
        tick();
        kill_b = 4'h0;
        check("b_double_kill_score", score_b, 16'd2);
        check("b_double_kill_clear", lane_full_b & kmask, 4'h0);

        n = 0;
        while (lane_full_b != 4'hF && !game_over_b && n < 1500) begin tick(); n++; end
        check("b_all_full", {game_over_b, lane_full_b}, {1'b0, 4'hF});
        repeat (6) tick();
        check("b_stays_full", {q_Play_b, lane_full_b}, {1'b1, 4'hF});
        n = 0;
        while (!game_over_b && n < 500) begin tick(); n++; end
        check("b_over", {q_Over_b, game_over_b, score_b}, {1'b1, 1'b1, 16'd2});
        tick();
        check("b_init", {q_Init_b, lane_full_b, game_over_b, score_b}, {1'b1, 4'h0, 1'b0, 16'd2});

        // Asynchronous reset mid-PLAY
        play_flag = 1'b1;
        tick();
        play_flag = 1'b0;
        n = 0;
        while (lane_full == 4'h0 && n < 20) begin tick(); n++; end
        kill = lane_full;
        tick();
        kill = 4'h0;
        check("pre_reset_score", score, 16'd1);
        n = 0;
        while (lane_full == 4'h0 && n < 20) begin tick(); n++; end
        check("pre_reset_full", {q_Play, (lane_full != 4'h0)}, 2'b11);
        #3;
        Reset = 1'b1;
        #1;
        check("async_reset", {q_Over, q_Play, q_Init, lane_full, game_over, score},
              {3'b001, 4'h0, 1'b0, 16'h0});
        tick();
        Reset = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
